// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types, defaults and helpers for the store buffer
package sb_pkg;

    localparam int SB_XLEN    = 32;
    localparam int SB_DEPTH   = 4;
    localparam int SB_WADDR_W = SB_XLEN - 2;

    // One buffered store: word address only, byte offset is always zero
    typedef struct packed {
        logic                  valid;
        logic [SB_WADDR_W-1:0] waddr;
        logic [31:0]           data;
    } sb_entry_t;

    // Ceiling log2 usable in constant expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - one-hot word-address compare across all buffer entries
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int IW   = clog2(DEPTH)
) (
    input  sb_entry_t             entries [DEPTH],
    input  logic [SB_WADDR_W-1:0] waddr,
    output logic                  hit,
    output logic [IW-1:0]         index,
    output logic [31:0]           data
);

    logic [DEPTH-1:0] match;

    // Coalescing guarantees at most one match, so OR-combining is a clean mux
    always_comb begin
        match = '0;
        index = '0;
        data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entries[i].valid && (entries[i].waddr == waddr);
            if (match[i]) begin
                index = index | IW'(i);
                data  = data | entries[i].data;
            end
        end
        hit = |match;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - coalescing word store buffer in front of data_mem
module store_buffer
    import sb_pkg::*;
#(
    parameter int XLEN  = SB_XLEN,
    parameter int DEPTH = SB_DEPTH,
    localparam int PW   = clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    input  logic [XLEN-1:0] st_addr,
    input  logic [31:0]     st_wdata,
    output logic            st_stall,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    output logic [31:0]     ld_rdata,
    output logic            ld_stall,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata,
    output logic            empty,
    output logic [CW-1:0]   count
);

    sb_entry_t       entries [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   cnt;

    logic            full;
    logic            drain;
    logic            ld_hit;
    logic [PW-1:0]   ld_idx_unused;
    logic [31:0]     ld_fwd;
    logic            st_hit;
    logic [PW-1:0]   st_idx;
    logic [31:0]     st_data_unused;
    logic            coalesce;
    logic            push;
    logic [1:0]      addr_lsb_unused;

    assign addr_lsb_unused = st_addr[1:0] | ld_addr[1:0];

    sb_match #(.DEPTH(DEPTH)) u_ld_match (
        .entries (entries),
        .waddr   (ld_addr[XLEN-1:2]),
        .hit     (ld_hit),
        .index   (ld_idx_unused),
        .data    (ld_fwd)
    );

    sb_match #(.DEPTH(DEPTH)) u_st_match (
        .entries (entries),
        .waddr   (st_addr[XLEN-1:2]),
        .hit     (st_hit),
        .index   (st_idx),
        .data    (st_data_unused)
    );

    // Drain arbitration: retire in idle slots, or force a retire when full so loads never starve
    always_comb begin
        full     = (cnt == CW'(DEPTH));
        drain    = (cnt != '0) && (!ld_valid || full);
        ld_stall = ld_valid && full;
        mem_read = ld_valid && !full;
        // An entry leaving this cycle cannot absorb the store; it must follow it in order
        coalesce = st_valid && st_hit && !(drain && (st_idx == head));
        push     = st_valid && !coalesce && (!full || drain);
        st_stall = st_valid && !coalesce && !push;
        empty    = (cnt == '0);
        count    = cnt;
    end

    // data_mem port and load data muxing; address is zero when idle
    always_comb begin
        mem_write = drain;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_rdata  = '0;
        if (drain) begin
            mem_addr  = {entries[head].waddr, 2'b00};
            mem_wdata = entries[head].data;
        end else if (mem_read) begin
            mem_addr  = ld_addr;
        end
        if (ld_valid) begin
            ld_rdata = ld_hit ? ld_fwd : mem_rdata;
        end
    end

    // Entry storage, FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (coalesce) begin
                entries[st_idx].data <= st_wdata;
            end
            if (drain) begin
                entries[head].valid <= 1'b0;
                head <= head + 1'b1;
            end
            // Push after pop so a full-buffer push into the freed head slot wins
            if (push) begin
                entries[tail] <= '{valid: 1'b1, waddr: st_addr[XLEN-1:2], data: st_wdata};
                tail <= tail + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(drain);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed checks of store_buffer against a queue model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_stall;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_rdata;
    logic        ld_stall;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        empty;
    logic [2:0]  count;

    int checks;
    int failures;

    store_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_stall  (st_stall),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_rdata  (ld_rdata),
        .ld_stall  (ld_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .empty     (empty),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_mem stand-in: 256 words, combinational read, posedge write
    logic [31:0] dmem [0:255];
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of pending word stores plus the memory they retire into
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;
    ent_t        q[$];
    logic [31:0] ref_mem [0:255];

    int          m_n;
    int          m_si;
    bit          m_full;
    bit          m_drn;
    bit          m_coal;
    bit          m_push;
    logic [31:0] m_ld;
    logic [31:0] m_addr;
    ent_t        m_new;

    // Compare every cycle, then advance the model by one clock
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_mem_write", 32'(mem_write), 32'd0);
        end else begin
            m_n    = q.size();
            m_full = (m_n == DEPTH);
            m_drn  = (m_n > 0) && (!ld_valid || m_full);
            chk("count", 32'(count), 32'(m_n));
            chk("empty", 32'(empty), 32'(m_n == 0));
            chk("mem_write", 32'(mem_write), 32'(m_drn));
            chk("mem_read", 32'(mem_read), 32'(ld_valid && !m_full));
            chk("ld_stall", 32'(ld_stall), 32'(ld_valid && m_full));
            m_addr = m_drn ? q[0].addr : ((ld_valid && !m_full) ? ld_addr : 32'd0);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_drn ? q[0].data : 32'd0);
            if (!ld_valid) begin
                chk("ld_rdata_idle", ld_rdata, 32'd0);
            end else if (!m_full) begin
                m_ld = ref_mem[ld_addr[9:2]];
                foreach (q[i]) if (q[i].addr == ld_addr) m_ld = q[i].data;
                chk("ld_rdata", ld_rdata, m_ld);
            end
            m_si   = -1;
            m_coal = 1'b0;
            m_push = 1'b0;
            if (st_valid) begin
                foreach (q[i]) if (q[i].addr == st_addr) m_si = i;
                m_coal = (m_si >= 0) && !(m_drn && m_si == 0);
                m_push = !m_coal && (!m_full || m_drn);
                chk("st_stall", 32'(st_stall), 32'(!(m_coal || m_push)));
                if (m_coal) q[m_si].data = st_wdata;
            end else begin
                chk("st_stall_idle", 32'(st_stall), 32'd0);
            end
            if (m_drn) begin
                ref_mem[q[0].addr[9:2]] = q[0].data;
                void'(q.pop_front());
            end
            if (m_push) begin
                m_new.addr = st_addr;
                m_new.data = st_wdata;
                q.push_back(m_new);
            end
        end
    end

    task automatic drive(input bit s, input logic [31:0] sa, input logic [31:0] sd,
                         input bit l, input logic [31:0] la);
        st_valid = s;
        st_addr  = sa;
        st_wdata = sd;
        ld_valid = l;
        ld_addr  = la;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();

        // Reset state, idle outputs
        @(negedge clk);
        chk("t0_count", 32'(count), 32'd0);
        chk("t0_empty", 32'(empty), 32'd1);
        chk("t0_mem_rw", 32'({mem_read, mem_write}), 32'd0);
        chk("t0_mem_addr", mem_addr, 32'd0);
        chk("t0_ld_rdata", ld_rdata, 32'd0);
        next_cycle();

        // 1: store then idle drains it
        drive(1, 32'h10, 32'hAAAA_0001, 0, 0);
        @(negedge clk);
        chk("t1_st_stall", 32'(st_stall), 32'd0);
        chk("t1_no_write", 32'(mem_write), 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_mem_write", 32'(mem_write), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_wdata", mem_wdata, 32'hAAAA_0001);
        next_cycle();
        @(negedge clk);
        chk("t1_empty", 32'(empty), 32'd1);
        next_cycle();

        // 2: store then back-to-back load forwards from the buffer
        drive(1, 32'h20, 32'h11, 0, 0);
        next_cycle();
        drive(0, 0, 0, 1, 32'h20);
        @(negedge clk);
        chk("t2_ld_rdata", ld_rdata, 32'h11);
        chk("t2_no_write", 32'(mem_write), 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_drain_addr", mem_addr, 32'h20);
        chk("t2_drain_data", mem_wdata, 32'h11);
        next_cycle();

        // 3: coalescing (second store issued alongside a load so no drain competes)
        drive(1, 32'h30, 32'h1, 0, 0);
        next_cycle();
        drive(1, 32'h30, 32'h2, 1, 32'h30);
        @(negedge clk);
        chk("t3_pre_store_ld", ld_rdata, 32'h1);
        next_cycle();
        drive(0, 0, 0, 1, 32'h30);
        @(negedge clk);
        chk("t3_count", 32'(count), 32'd1);
        chk("t3_ld_rdata", ld_rdata, 32'h2);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_drain_data", mem_wdata, 32'h2);
        next_cycle();
        @(negedge clk);
        chk("t3_empty", 32'(empty), 32'd1);
        next_cycle();

        // 4: fill, then store and load against a full buffer
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h40 + 32'(4 * i), 32'hC000_0040 + 32'(4 * i), 1, 32'h80);
            next_cycle();
        end
        drive(1, 32'h50, 32'hC000_0050, 0, 0);
        @(negedge clk);
        chk("t4_full_count", 32'(count), 32'd4);
        chk("t4_st_stall", 32'(st_stall), 32'd0);
        chk("t4_drain_addr", mem_addr, 32'h40);
        next_cycle();
        drive(0, 0, 0, 1, 32'h44);
        @(negedge clk);
        chk("t4_ld_stall", 32'(ld_stall), 32'd1);
        chk("t4_drain2_addr", mem_addr, 32'h44);
        next_cycle();
        @(negedge clk);
        chk("t4_ld_served", 32'(ld_stall), 32'd0);
        chk("t4_ld_rdata", ld_rdata, 32'hC000_0044);
        next_cycle();

        // 5: full buffer, store to the head word while it drains is appended
        drive(1, 32'h60, 32'hC000_0060, 1, 32'h80);
        next_cycle();
        drive(1, 32'h48, 32'hBEEF_0048, 0, 0);
        @(negedge clk);
        chk("t5_st_stall", 32'(st_stall), 32'd0);
        chk("t5_drain_addr", mem_addr, 32'h48);
        chk("t5_drain_old", mem_wdata, 32'hC000_0048);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_count", 32'(count), 32'd4);
        repeat (5) next_cycle();
        chk("t5_dmem_newer", dmem[32'h48 >> 2], 32'hBEEF_0048);

        // 6: reset in the middle of draining three entries
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h70 + 32'(4 * i), 32'hD000_0070 + 32'(4 * i), 1, 32'h80);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_draining", 32'(mem_write), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) begin
            next_cycle();
            chk("t6_no_write", 32'(mem_write), 32'd0);
        end
        chk("t6_dmem_74", dmem[32'h74 >> 2], 32'd0);
        chk("t6_dmem_78", dmem[32'h78 >> 2], 32'd0);

        // Randomized traffic on a small word set to provoke coalescing and full stalls
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            drive(r < 45 || r >= 95,
                  32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom,
                  r >= 45 && r < 85 || r >= 95,
                  32'h100 + 32'(4 * $urandom_range(0, 7)));
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        repeat (8) next_cycle();
        chk("final_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 256; i++) begin
            chk("final_dmem", dmem[i], ref_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
